// File: rtl/noc_packet.sv
// Shared NoC flit format and per-VC framing state used by the router datapath.
package noc_packet;

   localparam int VC_COUNT  = 4;
   localparam int PAYLOAD_W = 16;

   typedef struct packed {
      logic                 head;
      logic                 tail;
      logic [PAYLOAD_W-1:0] payload;
   } noc_flit_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } vc_state_t;

endpackage

// File: rtl/noc_input_buffer_vc_fifo.sv
// Single-VC circular flit FIFO: pointer pair plus occupancy counter, combinational head read.
module vc_fifo
   import noc_packet::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  noc_flit_t        wdata,
   output noc_flit_t        head,
   output logic             empty,
   output logic             full,
   output logic [OCC_W-1:0] occupancy
);

   noc_flit_t        mem [DEPTH];
   noc_flit_t        last_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic             do_push;
   logic             do_pop;

   assign empty     = (occ_q == '0);
   assign full      = (occ_q == OCC_W'(DEPTH));
   assign occupancy = occ_q;
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   // An empty FIFO shows the most recently popped flit rather than a stale slot.
   assign head = empty ? last_q : mem[rd_ptr_q];

   // NOTE: storage is deliberately not reset; a slot is only read after a push has written it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
         last_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            last_q   <= mem[rd_ptr_q];
         end
         case ({do_push, do_pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: rtl/noc_input_buffer.sv
// Router input-port VC buffer: per-VC FIFOs, credit return, packet framing and sticky error flags.
module noc_input_buffer
   import noc_packet::*;
#(
   parameter int VC_COUNT = noc_packet::VC_COUNT,
   parameter int DEPTH    = 4,
   localparam int VC_W  = $clog2(VC_COUNT),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  noc_flit_t           flit_in,
   input  logic                flit_in_valid,
   input  logic [VC_W-1:0]     flit_in_vc,
   input  logic [VC_COUNT-1:0] pop,
   output logic                buffer_empty     [VC_COUNT],
   output noc_flit_t           buffer_head_flit [VC_COUNT],
   output logic [VC_COUNT-1:0] credit_out,
   output logic [OCC_W-1:0]    vc_occupancy     [VC_COUNT],
   output logic [VC_COUNT-1:0] vc_active,
   output logic                overflow_error,
   output logic                underflow_error,
   output logic                framing_error
);

   vc_state_t           state_q [VC_COUNT];
   logic [VC_COUNT-1:0] push_v;
   logic [VC_COUNT-1:0] empty_v;
   logic [VC_COUNT-1:0] full_v;
   logic                accept;
   logic                framing_bad;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      push_v    = '0;
      empty_v   = '0;
      vc_active = '0;
      for (int v = 0; v < VC_COUNT; v++) begin
         push_v[v]    = flit_in_valid && (flit_in_vc == VC_W'(v));
         empty_v[v]   = buffer_empty[v];
         vc_active[v] = (state_q[v] == ACTIVE);
      end
   end

   assign accept      = flit_in_valid && !full_v[flit_in_vc];
   assign framing_bad = (state_q[flit_in_vc] == IDLE) ? !flit_in.head : flit_in.head;

   for (genvar v = 0; v < VC_COUNT; v++) begin : g_vc
      vc_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (push_v[v]),
         .pop       (pop[v]),
         .wdata     (flit_in),
         .head      (buffer_head_flit[v]),
         .empty     (buffer_empty[v]),
         .full      (full_v[v]),
         .occupancy (vc_occupancy[v])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_out      <= '0;
         overflow_error  <= 1'b0;
         underflow_error <= 1'b0;
         framing_error   <= 1'b0;
         for (int v = 0; v < VC_COUNT; v++) state_q[v] <= IDLE;
      end else begin
         credit_out <= pop & ~empty_v;
         if (flit_in_valid && full_v[flit_in_vc]) overflow_error <= 1'b1;
         if (|(pop & empty_v))                    underflow_error <= 1'b1;
         if (accept && framing_bad)               framing_error <= 1'b1;
         // Framing only advances on flits that actually entered the FIFO.
         if (accept) begin
            case (state_q[flit_in_vc])
               IDLE:    if (flit_in.head && !flit_in.tail) state_q[flit_in_vc] <= ACTIVE;
               ACTIVE:  if (!flit_in.head && flit_in.tail) state_q[flit_in_vc] <= IDLE;
               default: state_q[flit_in_vc] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer: reference queues per VC plus a framing table.
module tb_noc_input_buffer;
   import noc_packet::*;

   localparam int DEPTH = 4;
   localparam int VC_W  = $clog2(VC_COUNT);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic                clk = 1'b0;
   logic                rst_n;
   noc_flit_t           flit_in;
   logic                flit_in_valid;
   logic [VC_W-1:0]     flit_in_vc;
   logic [VC_COUNT-1:0] pop;
   logic                buffer_empty     [VC_COUNT];
   noc_flit_t           buffer_head_flit [VC_COUNT];
   logic [VC_COUNT-1:0] credit_out;
   logic [OCC_W-1:0]    vc_occupancy     [VC_COUNT];
   logic [VC_COUNT-1:0] vc_active;
   logic                overflow_error;
   logic                underflow_error;
   logic                framing_error;

   noc_input_buffer #(.VC_COUNT(VC_COUNT), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flit_in          (flit_in),
      .flit_in_valid    (flit_in_valid),
      .flit_in_vc       (flit_in_vc),
      .pop              (pop),
      .buffer_empty     (buffer_empty),
      .buffer_head_flit (buffer_head_flit),
      .credit_out       (credit_out),
      .vc_occupancy     (vc_occupancy),
      .vc_active        (vc_active),
      .overflow_error   (overflow_error),
      .underflow_error  (underflow_error),
      .framing_error    (framing_error)
   );

   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   noc_flit_t           sb [VC_COUNT][$];
   logic [VC_COUNT-1:0] exp_credit;
   logic [VC_COUNT-1:0] exp_act;
   logic                exp_ovf, exp_unf, exp_frm;
   logic [PAYLOAD_W-1:0] tag;

   typedef struct {
      logic                valid;
      int                  vc;
      logic                hd;
      logic                tl;
      logic [VC_COUNT-1:0] pop_v;
      logic [VC_COUNT-1:0] exp_active;
      logic                exp_frm;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < VC_COUNT; v++) sb[v].delete();
      exp_credit = '0;
      exp_act    = '0;
      exp_ovf    = 1'b0;
      exp_unf    = 1'b0;
      exp_frm    = 1'b0;
   endtask

   task automatic check_state();
      for (int v = 0; v < VC_COUNT; v++) begin
         check($sformatf("occupancy[%0d]", v), 64'(vc_occupancy[v]), 64'(sb[v].size()));
         check($sformatf("empty[%0d]", v), 64'(buffer_empty[v]), 64'(sb[v].size() == 0));
         check($sformatf("credit[%0d]", v), 64'(credit_out[v]), 64'(exp_credit[v]));
         check($sformatf("active[%0d]", v), 64'(vc_active[v]), 64'(exp_act[v]));
         if (sb[v].size() != 0)
            check($sformatf("head[%0d]", v), 64'(buffer_head_flit[v]), 64'(sb[v][0]));
      end
      check("overflow_error", 64'(overflow_error), 64'(exp_ovf));
      check("underflow_error", 64'(underflow_error), 64'(exp_unf));
      check("framing_error", 64'(framing_error), 64'(exp_frm));
   endtask

   // Called at posedge+1; drives one cycle of stimulus, updates the model, checks after the edge.
   task automatic cycle(input logic valid, input int vc, input logic hd, input logic tl,
                        input logic [VC_COUNT-1:0] pop_v);
      noc_flit_t           f;
      logic                full_b;
      logic [VC_COUNT-1:0] nc;
      f.head    = hd;
      f.tail    = tl;
      f.payload = tag;
      tag       = tag + 1'b1;
      flit_in       = f;
      flit_in_valid = valid;
      flit_in_vc    = VC_W'(vc);
      pop           = pop_v;
      nc     = '0;
      full_b = (sb[vc].size() == DEPTH);
      for (int v = 0; v < VC_COUNT; v++) begin
         if (pop_v[v]) begin
            if (sb[v].size() == 0) exp_unf = 1'b1;
            else begin
               sb[v].delete(0);
               nc[v] = 1'b1;
            end
         end
      end
      if (valid) begin
         if (full_b) exp_ovf = 1'b1;
         else begin
            sb[vc].push_back(f);
            if (!exp_act[vc]) begin
               if (!hd) exp_frm = 1'b1;
               else if (!tl) exp_act[vc] = 1'b1;
            end else begin
               if (hd) exp_frm = 1'b1;
               else if (tl) exp_act[vc] = 1'b0;
            end
         end
      end
      exp_credit = nc;
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic idle();
      cycle(1'b0, 0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      noc_flit_t first_flit;
      noc_flit_t last_flit;
      int        credits;

      tag           = '0;
      rst_n         = 1'b0;
      flit_in       = '0;
      flit_in_valid = 1'b0;
      flit_in_vc    = '0;
      pop           = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      check_state();
      for (int v = 0; v < VC_COUNT; v++)
         check($sformatf("reset_head[%0d]", v), 64'(buffer_head_flit[v]), 64'(0));

      // Fill VC 2 to capacity, then overflow it
      first_flit = '{head: 1'b1, tail: 1'b0, payload: tag};
      cycle(1'b1, 2, 1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 2, 1'b0, 1'b0, '0);
      check("fill_occ_full", 64'(vc_occupancy[2]), 64'(4));
      cycle(1'b1, 2, 1'b0, 1'b0, '0);
      check("overflow_set", 64'(overflow_error), 64'(1));
      check("overflow_head_kept", 64'(buffer_head_flit[2]), 64'(first_flit));

      // Drain VC 2; empty head holds the last popped flit
      last_flit = sb[2][3];
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b0, 4'b0100);
      check("drain_empty", 64'(buffer_empty[2]), 64'(1));
      check("drain_head_hold", 64'(buffer_head_flit[2]), 64'(last_flit));
      idle();

      // Concurrent push/pop on VC 2 at occupancy 2
      cycle(1'b1, 2, 1'b0, 1'b0, '0);
      cycle(1'b1, 2, 1'b0, 1'b0, '0);
      credits = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 2, 1'b0, 1'b0, 4'b0100);
         if (credit_out[2]) credits++;
      end
      check("concurrent_credits", 64'(credits), 64'(10));
      check("concurrent_occ", 64'(vc_occupancy[2]), 64'(2));
      idle();

      // Framing table
      tbl[0] = '{1'b1, 0, 1'b1, 1'b0, 4'b0000, 4'b0101, 1'b0};
      tbl[1] = '{1'b1, 0, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0};
      tbl[2] = '{1'b1, 0, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0};
      tbl[3] = '{1'b1, 1, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b1};
      tbl[4] = '{1'b1, 3, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b1};
      tbl[5] = '{1'b1, 2, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1};
      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].valid, tbl[i].vc, tbl[i].hd, tbl[i].tl, tbl[i].pop_v);
         check($sformatf("tbl%0d_active", i), 64'(vc_active), 64'(tbl[i].exp_active));
         check($sformatf("tbl%0d_framing", i), 64'(framing_error), 64'(tbl[i].exp_frm));
      end

      // Underflow on VC 1 after emptying it
      cycle(1'b0, 0, 1'b0, 1'b0, 4'b0010);
      check("unf_pre_clear", 64'(underflow_error), 64'(0));
      cycle(1'b0, 0, 1'b0, 1'b0, 4'b0010);
      check("unf_set", 64'(underflow_error), 64'(1));
      check("unf_no_credit", 64'(credit_out[1]), 64'(0));
      check("unf_occ", 64'(vc_occupancy[1]), 64'(0));

      // Reset mid-packet: VC 0 holds 3 flits and is ACTIVE, VC 3 credit pending
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0, 4'b0001);
      cycle(1'b1, 0, 1'b1, 1'b0, '0);
      cycle(1'b1, 0, 1'b0, 1'b0, '0);
      cycle(1'b1, 0, 1'b0, 1'b0, 4'b1000);
      check("pre_reset_occ0", 64'(vc_occupancy[0]), 64'(3));
      check("pre_reset_active0", 64'(vc_active[0]), 64'(1));
      check("pre_reset_credit3", 64'(credit_out[3]), 64'(1));
      flit_in_valid = 1'b0;
      pop           = '0;
      rst_n         = 1'b0;
      #1;
      model_reset();
      check_state();
      for (int v = 0; v < VC_COUNT; v++)
         check($sformatf("rst_head[%0d]", v), 64'(buffer_head_flit[v]), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) idle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
